// File: rtl/data_memory_sized.sv
// Byte-addressed little-endian RV64/RV32 data memory with valid/ready request, fixed access latency
// and error response. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module data_memory_sized #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned LATENCY     = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned NumBytes = XLEN / 8;
  localparam int unsigned AddrW    = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  LastCnt  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, uns_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic [1:0]        size_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;
  logic              commit;

  logic [7:0]        mem [DEPTH_BYTES];

  logic              cur_write, cur_uns;
  logic [XLEN-1:0]   cur_addr, cur_wdata;
  logic [1:0]        cur_size;
  logic [3:0]        nbytes;
  logic [AddrW-1:0]  base;
  logic [XLEN:0]     last_addr;
  logic              size_bad, range_bad, misalign, acc_err;
  logic [XLEN-1:0]   raw, load_val;
  logic              sign;

  // With LATENCY=0 the commit edge is the accept edge, so the live inputs stand in for the latch.
  always_comb begin
    if (state_q == StIdle) begin
      cur_write = req_write;
      cur_uns   = req_unsigned;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_size  = req_size;
    end else begin
      cur_write = write_q;
      cur_uns   = uns_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_size  = size_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = 4'd0;
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == LastCnt) begin
          state_d = StResp;
          commit  = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    unique case (cur_size)
      2'b00:   nbytes = 4'd1;
      2'b01:   nbytes = 4'd2;
      2'b10:   nbytes = 4'd4;
      default: nbytes = 4'd8;
    endcase
    base      = cur_addr[AddrW-1:0];
    size_bad  = (XLEN == 32) && (cur_size == 2'b11);
    // One extra bit so an address near the top of the space cannot wrap past the check.
    last_addr = {1'b0, cur_addr} + (XLEN+1)'(nbytes - 4'd1);
    range_bad = last_addr >= (XLEN+1)'(DEPTH_BYTES);
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign  = |(cur_addr[2:0] & (nbytes[2:0] - 3'd1));
`else
    misalign  = 1'b0;
`endif
    acc_err   = size_bad | range_bad | misalign;
  end

  always_comb begin
    raw = '0;
    for (int k = 0; k < NumBytes; k++) begin
      if (k < int'(nbytes)) raw[8*k +: 8] = mem[base + AddrW'(k)];
    end
    unique case (cur_size)
      2'b00:   sign = raw[7];
      2'b01:   sign = raw[15];
      2'b10:   sign = raw[31];
      default: sign = raw[XLEN-1];
    endcase
    load_val = raw;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= 8 * int'(nbytes) && !cur_uns && sign) load_val[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'b00;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req_valid) begin
        write_q <= req_write;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
      end
      if (commit) begin
        err_q   <= acc_err;
        rdata_q <= (cur_write || acc_err) ? '0 : load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && commit && cur_write && !acc_err) begin
      for (int k = 0; k < NumBytes; k++) begin
        if (k < int'(nbytes)) mem[base + AddrW'(k)] <= cur_wdata[8*k +: 8];
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: LATENCY=1 instance for data paths, LATENCY=3 for reset abort.
module tb_data_memory_sized;

  logic        clk = 1'b0;
  logic        rst1, rst3, valid1, valid3;
  logic        req_write, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        ready1, ready3, rvalid1, rvalid3, err1, err3;
  logic [63:0] rdata1, rdata3;

  int n_checks = 0;
  int n_errors = 0;
  bit sel = 1'b0;

  logic        r_ready, r_valid, r_err;
  logic [63:0] r_rdata;
  assign r_ready = sel ? ready3 : ready1;
  assign r_valid = sel ? rvalid3 : rvalid1;
  assign r_err   = sel ? err3 : err1;
  assign r_rdata = sel ? rdata3 : rdata1;

  always #5 clk = ~clk;

  data_memory_sized #(.XLEN(64), .DEPTH_BYTES(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(rst1), .req_valid(valid1), .req_ready(ready1), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rvalid1), .rsp_rdata(rdata1), .rsp_err(err1)
  );

  data_memory_sized #(.XLEN(64), .DEPTH_BYTES(256), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(rst3), .req_valid(valid3), .req_ready(ready3), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rvalid3), .rsp_rdata(rdata3), .rsp_err(err3)
  );

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic txn(input bit s, input logic wr, input logic [63:0] addr, input logic [1:0] size,
                     input logic uns, input logic [63:0] wdata,
                     output logic [63:0] rd, output logic er);
    int n;
    sel = s;
    @(negedge clk);
    req_write = wr; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    if (s) valid3 = 1'b1; else valid1 = 1'b1;
    #1 chk("ready_idle", 64'(r_ready), 64'd1);
    @(posedge clk); #1;
    valid1 = 1'b0; valid3 = 1'b0;
    req_wdata = ~wdata; req_addr = addr + 64'd1; // post-accept changes must be ignored
    chk("ready_after_accept", 64'(r_ready), 64'd0);
    chk("valid_early", 64'(r_valid), 64'd0);
    n = 0;
    while (!r_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), s ? 64'd3 : 64'd1);
    rd = r_rdata;
    er = r_err;
    chk("ready_in_resp", 64'(r_ready), 64'd0);
    @(posedge clk); #1;
    chk("valid_one_cycle", 64'(r_valid), 64'd0);
    chk("ready_back", 64'(r_ready), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic        er;

    vecs[0]  = '{1'b1, 64'd16,  2'b11, 1'b0, 64'h1122334455667788, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 64'd16,  2'b11, 1'b0, 64'h0, 64'h1122334455667788, 1'b0};
    vecs[2]  = '{1'b1, 64'd40,  2'b00, 1'b0, 64'hFFFFFFFFFFFFFF80, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 64'd40,  2'b00, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 64'd40,  2'b00, 1'b1, 64'h0, 64'h0000000000000080, 1'b0};
    vecs[5]  = '{1'b0, 64'd40,  2'b11, 1'b0, 64'h0, 64'h0000000000000080, 1'b0};
    vecs[6]  = '{1'b1, 64'd8,   2'b10, 1'b0, 64'h12345678DEADBEEF, 64'h0, 1'b0};
    vecs[7]  = '{1'b0, 64'd10,  2'b01, 1'b0, 64'h0, 64'hFFFFFFFFFFFFDEAD, 1'b0};
    vecs[8]  = '{1'b0, 64'd8,   2'b10, 1'b1, 64'h0, 64'h00000000DEADBEEF, 1'b0};
    vecs[9]  = '{1'b0, 64'd8,   2'b10, 1'b0, 64'h0, 64'hFFFFFFFFDEADBEEF, 1'b0};
    vecs[10] = '{1'b0, 64'd8,   2'b11, 1'b1, 64'h0, 64'h00000000DEADBEEF, 1'b0};
    vecs[11] = '{1'b0, 64'd252, 2'b11, 1'b0, 64'h0, 64'h0, 1'b1};
    vecs[12] = '{1'b0, 64'd248, 2'b11, 1'b0, 64'h0, 64'h0, 1'b0};
    vecs[13] = '{1'b1, 64'd252, 2'b11, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1};
    vecs[14] = '{1'b0, 64'd248, 2'b11, 1'b0, 64'h0, 64'h0, 1'b0};
    vecs[15] = '{1'b0, 64'd255, 2'b00, 1'b0, 64'h0, 64'h0, 1'b0};
    vecs[16] = '{1'b0, 64'd255, 2'b01, 1'b0, 64'h0, 64'h0, 1'b1};
    vecs[17] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, 2'b00, 1'b0, 64'h0, 64'h0, 1'b1};
    vecs[18] = '{1'b1, 64'd0,   2'b11, 1'b0, 64'h0000965544330201, 64'h0, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs[19] = '{1'b0, 64'd2,   2'b10, 1'b0, 64'h0, 64'h0, 1'b1};
`else
    vecs[19] = '{1'b0, 64'd2,   2'b10, 1'b0, 64'h0, 64'hFFFFFFFF96554433, 1'b0};
`endif
    vecs[20] = '{1'b0, 64'd4,   2'b01, 1'b1, 64'h0, 64'h0000000000009655, 1'b0};
    vecs[21] = '{1'b0, 64'd4,   2'b01, 1'b0, 64'h0, 64'hFFFFFFFFFFFF9655, 1'b0};
    vecs[22] = '{1'b1, 64'd42,  2'b01, 1'b0, 64'h000000001234BEEF, 64'h0, 1'b0};
    vecs[23] = '{1'b0, 64'd40,  2'b11, 1'b0, 64'h0, 64'h00000000BEEF0080, 1'b0};

    rst1 = 1'b0; rst3 = 1'b0; valid1 = 1'b0; valid3 = 1'b0;
    req_write = 1'b0; req_addr = '0; req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0;
    #1;
    chk("reset_ready1", 64'(ready1), 64'd1);
    chk("reset_valid1", 64'(rvalid1), 64'd0);
    chk("reset_rdata1", rdata1, 64'h0);
    chk("reset_err1", 64'(err1), 64'd0);
    chk("reset_ready3", 64'(ready3), 64'd1);
    chk("reset_valid3", 64'(rvalid3), 64'd0);
    repeat (2) @(negedge clk);
    rst1 = 1'b1; rst3 = 1'b1;

    for (int i = 0; i < 24; i++) begin
      txn(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_hold", i), rdata1, vecs[i].exp_rdata);
    end

    // Reset pulsed during WAIT must abort the pending store.
    txn(1'b1, 1'b1, 64'd24, 2'b11, 1'b0, 64'h0102030405060708, rd, er);
    chk("l3_store_err", 64'(er), 64'd0);
    txn(1'b1, 1'b0, 64'd24, 2'b11, 1'b0, 64'h0, rd, er);
    chk("l3_load_first", rd, 64'h0102030405060708);
    sel = 1'b1;
    @(negedge clk);
    req_write = 1'b1; req_addr = 64'd24; req_size = 2'b11; req_unsigned = 1'b0;
    req_wdata = 64'hA5A5A5A5A5A5A5A5;
    valid3 = 1'b1;
    @(posedge clk); #1;
    valid3 = 1'b0;
    chk("abort_accepted", 64'(ready3), 64'd0);
    @(posedge clk); #1;
    chk("abort_hold_rdata", rdata3, 64'h0102030405060708);
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    chk("abort_ready", 64'(ready3), 64'd1);
    chk("abort_valid", 64'(rvalid3), 64'd0);
    chk("abort_rdata", rdata3, 64'h0);
    chk("abort_err", 64'(err3), 64'd0);
    @(negedge clk);
    rst3 = 1'b1;
    txn(1'b1, 1'b0, 64'd24, 2'b11, 1'b0, 64'h0, rd, er);
    chk("abort_mem_unchanged", rd, 64'h0102030405060708);
    chk("abort_load_err", 64'(er), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
